// File: rtl/rx_dpram_ctl_if.sv
// -----------------------------------------------------------------------------
// rx_dpram_ctl_if
//   Bundle of the write/read port signals of the rx_dpram_ctl receive buffer.
//
//   Handshake semantics (there is no ready signal):
//     - A write is taken on every rising clk edge where wr_en_n is 0 and the
//       buffer is not sweeping (init_busy low).
//     - A read is taken on every rising clk edge where rd_en is 1 and the
//       buffer is not sweeping. Each taken read produces exactly one rd_valid
//       pulse, 1 + OUT_REG cycles later, in request order. rd_data and
//       parity_err belong to the cycle in which rd_valid is high; rd_data
//       keeps the last read word while rd_valid is low.
//
//   Signals:
//     wr_en_n, wr_addr, wr_data, par_inject : write port (master -> slave)
//     rd_en, rd_addr                         : read request (master -> slave)
//     rd_data, rd_valid, parity_err          : read response (slave -> master)
//     init_busy                              : clear sweep in progress
//     dbg_state                              : controller state (0 INIT, 1 RUN)
// -----------------------------------------------------------------------------
interface rx_dpram_ctl_if #(
    parameter int DWIDTH = 36,
    parameter int AWIDTH = 12
);
    logic              wr_en_n;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              par_inject;
    logic              rd_en;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              parity_err;
    logic              init_busy;
    logic [1:0]        dbg_state;

    modport master (
        output wr_en_n, wr_addr, wr_data, par_inject, rd_en, rd_addr,
        input  rd_data, rd_valid, parity_err, init_busy, dbg_state
    );

    modport slave (
        input  wr_en_n, wr_addr, wr_data, par_inject, rd_en, rd_addr,
        output rd_data, rd_valid, parity_err, init_busy, dbg_state
    );
endinterface

// File: rtl/rx_dpram_ctl.sv
// -----------------------------------------------------------------------------
// rx_dpram_ctl
//   Single-clock simple dual-port receive buffer RAM (one write port, one read
//   port) between the receive MAC datapath and the host-side DMA reader.
//   After reset an optional sweep writes zero to every word; user accesses are
//   ignored while it runs. Reads are write-first on an address collision and
//   return data after 1 + OUT_REG cycles together with a rd_valid strobe.
//
//   Optional feature macro: RX_DPRAM_PARITY_EN
//     defined   : each word stores an extra even-parity bit (XOR par_inject);
//                 parity_err flags a mismatch on the word read back.
//     undefined : no parity storage, parity_err is constant 0.
//
//   Ports:
//     clk      : single clock, rising edge
//     reset_n  : synchronous reset, active low
//     bus      : rx_dpram_ctl_if.slave (write port, read port, status)
//
//   Parameters:
//     DWIDTH     : data width (1..72)
//     AWIDTH     : address width, depth = 2**AWIDTH
//     OUT_REG    : 1 adds an output register stage (read latency 2)
//     INIT_CLEAR : 1 clears the whole memory after reset
// -----------------------------------------------------------------------------
module rx_dpram_ctl #(
    parameter int DWIDTH     = 36,
    parameter int AWIDTH     = 12,
    parameter int OUT_REG    = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    rx_dpram_ctl_if.slave   bus
);

    localparam int DEPTH = 1 << AWIDTH;
`ifdef RX_DPRAM_PARITY_EN
    localparam int MW = DWIDTH + 1;
`else
    localparam int MW = DWIDTH;
`endif

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] init_cnt;
    logic              init_busy_q;

    logic [MW-1:0]     mem [DEPTH];

    logic              user_wr;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [MW-1:0]     mem_wword;
    logic [MW-1:0]     user_word;

    logic              rd_accept;
    logic              collide;
    logic [MW-1:0]     rd_word;
    logic              rd_perr;

    logic              s1_valid;
    logic [DWIDTH-1:0] s1_data;
    logic              s1_perr;

    // -------------------------------------------------------------------------
    // Controller: clear sweep then normal operation.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_cnt <= '0;
            if (INIT_CLEAR != 0) begin
                state       <= ST_INIT;
                init_busy_q <= 1'b1;
            end else begin
                state       <= ST_RUN;
                init_busy_q <= 1'b0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    // All-ones count is the last address of the sweep.
                    if (&init_cnt) begin
                        state       <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    init_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.init_busy = init_busy_q;
    assign bus.dbg_state = state;

    // -------------------------------------------------------------------------
    // Stored word for a user write (data plus optional parity bit).
    // -------------------------------------------------------------------------
`ifdef RX_DPRAM_PARITY_EN
    assign user_word = {(^bus.wr_data) ^ bus.par_inject, bus.wr_data};
`else
    assign user_word = bus.wr_data;
    logic unused_par_inject;
    assign unused_par_inject = bus.par_inject;
`endif

    assign user_wr = reset_n && (state == ST_RUN) && !bus.wr_en_n;

    // Write port source: sweep owns the port during INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wword = user_word;
        if (reset_n) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt;
                mem_wword = '0;
            end else if (!bus.wr_en_n) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    // -------------------------------------------------------------------------
    // Read port. A same-edge write to the read address wins: the new word
    // (including its parity bit) bypasses the array.
    // -------------------------------------------------------------------------
    assign rd_accept = reset_n && (state == ST_RUN) && bus.rd_en;
    assign collide   = rd_accept && user_wr && (bus.wr_addr == bus.rd_addr);
    assign rd_word   = collide ? user_word : mem[bus.rd_addr];

`ifdef RX_DPRAM_PARITY_EN
    // XOR over data and stored bit is 1 exactly when they disagree.
    assign rd_perr = ^rd_word;
`else
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_perr  <= 1'b0;
        end else begin
            s1_valid <= rd_accept;
            s1_perr  <= rd_accept & rd_perr;
            if (rd_accept) begin
                s1_data <= rd_word[DWIDTH-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional output stage: data, valid and error move together, no stall.
    // -------------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_valid;
            logic [DWIDTH-1:0] s2_data;
            logic              s2_perr;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_perr  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_perr  <= s1_perr;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign bus.rd_valid   = s2_valid;
            assign bus.rd_data    = s2_data;
            assign bus.parity_err = s2_perr;
        end else begin : g_no_out_reg
            assign bus.rd_valid   = s1_valid;
            assign bus.rd_data    = s1_data;
            assign bus.parity_err = s1_perr;
        end
    endgenerate

endmodule

// File: tb/tb_rx_dpram_ctl.sv
// -----------------------------------------------------------------------------
// tb_rx_dpram_ctl
//   Directed bench for rx_dpram_ctl. Three instances share one stimulus:
//     dut_a : AWIDTH=8, OUT_REG=0 (latency 1)
//     dut_b : AWIDTH=8, OUT_REG=1 (latency 2)
//     dut_c : AWIDTH=4, OUT_REG=0 (16-word sweep)
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rx_dpram_ctl;

    localparam int DW = 36;
`ifdef RX_DPRAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // shared stimulus
    logic          wr_en_n;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          par_inject;
    logic          rd_en;
    logic [7:0]    rd_addr;

    rx_dpram_ctl_if #(.DWIDTH(DW), .AWIDTH(8)) if_a ();
    rx_dpram_ctl_if #(.DWIDTH(DW), .AWIDTH(8)) if_b ();
    rx_dpram_ctl_if #(.DWIDTH(DW), .AWIDTH(4)) if_c ();

    assign if_a.wr_en_n = wr_en_n;  assign if_b.wr_en_n = wr_en_n;  assign if_c.wr_en_n = wr_en_n;
    assign if_a.wr_addr = wr_addr;  assign if_b.wr_addr = wr_addr;  assign if_c.wr_addr = wr_addr[3:0];
    assign if_a.wr_data = wr_data;  assign if_b.wr_data = wr_data;  assign if_c.wr_data = wr_data;
    assign if_a.par_inject = par_inject; assign if_b.par_inject = par_inject; assign if_c.par_inject = par_inject;
    assign if_a.rd_en = rd_en;      assign if_b.rd_en = rd_en;      assign if_c.rd_en = rd_en;
    assign if_a.rd_addr = rd_addr;  assign if_b.rd_addr = rd_addr;  assign if_c.rd_addr = rd_addr[3:0];

    rx_dpram_ctl #(.DWIDTH(DW), .AWIDTH(8), .OUT_REG(0), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a));
    rx_dpram_ctl #(.DWIDTH(DW), .AWIDTH(8), .OUT_REG(1), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b));
    rx_dpram_ctl #(.DWIDTH(DW), .AWIDTH(4), .OUT_REG(0), .INIT_CLEAR(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(if_c));

    // scoreboard counters
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int n      = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    task automatic idle();
        wr_en_n    = 1'b1;
        wr_addr    = '0;
        wr_data    = '0;
        par_inject = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [DW-1:0] d, input logic inj);
        wr_en_n = 1'b0; wr_addr = a; wr_data = d; par_inject = inj;
        tick();
        wr_en_n = 1'b1; par_inject = 1'b0;
    endtask

    // Single read; checks dut_a at latency 1 and dut_b at latency 2.
    task automatic rd_check(input string tag, input logic [7:0] a,
                            input logic [DW-1:0] d, input logic perr);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_a_valid"}, if_a.rd_valid, 1);
        chk({tag, "_a_data"},  if_a.rd_data, d);
        chk({tag, "_a_perr"},  if_a.parity_err, perr);
        chk({tag, "_b_early"}, if_b.rd_valid, 0);
        tick();
        chk({tag, "_a_pulse"}, if_a.rd_valid, 0);
        chk({tag, "_a_hold"},  if_a.rd_data, d);
        chk({tag, "_a_perr0"}, if_a.parity_err, 0);
        chk({tag, "_b_valid"}, if_b.rd_valid, 1);
        chk({tag, "_b_data"},  if_b.rd_data, d);
        chk({tag, "_b_perr"},  if_b.parity_err, perr);
        tick();
        chk({tag, "_b_pulse"}, if_b.rd_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (3) tick();

        // reset state
        chk("rst_busy_a", if_a.init_busy, 1);
        chk("rst_busy_c", if_c.init_busy, 1);
        chk("rst_valid_a", if_a.rd_valid, 0);
        chk("rst_valid_b", if_b.rd_valid, 0);
        chk("rst_data_b", if_b.rd_data, 0);
        chk("rst_perr_a", if_a.parity_err, 0);
        chk("rst_state_c", if_c.dbg_state, 0);

        // sweep on dut_c with user writes/reads held active (must be ignored)
        reset_n = 1'b1;
        n = 0;
        while (if_c.init_busy && n < 100) begin
            chk("init_valid_c", if_c.rd_valid, 0);
            wr_en_n = 1'b0; wr_addr = 8'h03; wr_data = 36'hF_FFFF_FFFF;
            rd_en = 1'b1; rd_addr = 8'h03;
            tick();
        end
        idle();
        chk("sweep_len_c", n, 16);
        chk("post_init_valid_c", if_c.rd_valid, 0);
        chk("run_state_c", if_c.dbg_state, 1);

        // back-to-back read of every dut_c word: all zero, valid every cycle
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                chk("clr_valid_c", if_c.rd_valid, 1);
                chk("clr_data_c", if_c.rd_data, 0);
            end
            if (i < 16) begin
                rd_en = 1'b1; rd_addr = 8'(i);
            end else begin
                rd_en = 1'b0;
            end
            tick();
        end
        chk("clr_end_valid_c", if_c.rd_valid, 0);
        chk("busy_mid_a", if_a.init_busy, 1);
        chk("busy_mid_valid_a", if_a.rd_valid, 0);
        chk("busy_mid_valid_b", if_b.rd_valid, 0);

        while (if_a.init_busy && n < 1000) tick();
        chk("sweep_len_a", n, 256);
        chk("sweep_done_b", if_b.init_busy, 0);

        // write issued during INIT did not land
        rd_check("init_wr_drop", 8'h03, 36'h0, 1'b0);

        // basic write then read
        wr(8'hA5, 36'h9_ABCD_1234, 1'b0);
        rd_check("wr_rd_a5", 8'hA5, 36'h9_ABCD_1234, 1'b0);

        // collision: write-first
        wr_en_n = 1'b0; wr_addr = 8'h10; wr_data = 36'h1_2345_6789;
        rd_en = 1'b1; rd_addr = 8'h10;
        tick();
        idle();
        chk("coll_a_valid", if_a.rd_valid, 1);
        chk("coll_a_data", if_a.rd_data, 36'h1_2345_6789);
        tick();
        chk("coll_b_valid", if_b.rd_valid, 1);
        chk("coll_b_data", if_b.rd_data, 36'h1_2345_6789);
        tick();

        // same edge, different addresses: independent
        wr_en_n = 1'b0; wr_addr = 8'h30; wr_data = 36'h5_5AA5_0F0F;
        rd_en = 1'b1; rd_addr = 8'hA5;
        tick();
        idle();
        chk("indep_a_data", if_a.rd_data, 36'h9_ABCD_1234);
        tick();
        chk("indep_b_data", if_b.rd_data, 36'h9_ABCD_1234);
        tick();
        rd_check("indep_wr30", 8'h30, 36'h5_5AA5_0F0F, 1'b0);

        // back-to-back reads, in order, full throughput
        wr(8'h40, 36'hA_0000_0001, 1'b0);
        wr(8'h41, 36'hB_0000_0002, 1'b0);
        wr(8'h42, 36'hC_0000_0003, 1'b0);
        rd_en = 1'b1; rd_addr = 8'h40;
        tick();
        chk("b2b_a0", if_a.rd_data, 36'hA_0000_0001);
        chk("b2b_b0_early", if_b.rd_valid, 0);
        rd_addr = 8'h41;
        tick();
        chk("b2b_a1", if_a.rd_data, 36'hB_0000_0002);
        chk("b2b_a1_valid", if_a.rd_valid, 1);
        chk("b2b_b0", if_b.rd_data, 36'hA_0000_0001);
        rd_addr = 8'h42;
        tick();
        rd_en = 1'b0;
        chk("b2b_a2", if_a.rd_data, 36'hC_0000_0003);
        chk("b2b_b1", if_b.rd_data, 36'hB_0000_0002);
        chk("b2b_b1_valid", if_b.rd_valid, 1);
        tick();
        chk("b2b_a_end", if_a.rd_valid, 0);
        chk("b2b_b2", if_b.rd_data, 36'hC_0000_0003);
        chk("b2b_b2_valid", if_b.rd_valid, 1);
        tick();
        chk("b2b_b_end", if_b.rd_valid, 0);

        // parity: injected error, then clean rewrite
        wr(8'h20, 36'h0_0000_0001, 1'b1);
        rd_check("par_inj", 8'h20, 36'h0_0000_0001, PAR);
        wr(8'h20, 36'h0_0000_0001, 1'b0);
        rd_check("par_clean", 8'h20, 36'h0_0000_0001, 1'b0);

        // parity carried through the collision bypass
        wr_en_n = 1'b0; wr_addr = 8'h21; wr_data = 36'h0_0000_0003; par_inject = 1'b1;
        rd_en = 1'b1; rd_addr = 8'h21;
        tick();
        idle();
        chk("par_coll_a_data", if_a.rd_data, 36'h0_0000_0003);
        chk("par_coll_a_perr", if_a.parity_err, PAR);
        tick();
        chk("par_coll_b_perr", if_b.parity_err, PAR);
        tick();

        // reset with reads in flight: nothing comes out
        rd_en = 1'b1; rd_addr = 8'hA5;
        tick();
        chk("flight_a_valid", if_a.rd_valid, 1);
        reset_n = 1'b0;
        tick();
        chk("flush_a_valid", if_a.rd_valid, 0);
        chk("flush_b_valid", if_b.rd_valid, 0);
        chk("flush_a_data", if_a.rd_data, 0);
        chk("flush_b_data", if_b.rd_data, 0);
        chk("flush_busy_a", if_a.init_busy, 1);
        tick();
        chk("flush2_b_valid", if_b.rd_valid, 0);
        idle();

        // reset mid-sweep at init_cnt = 7, sweep restarts at full length
        reset_n = 1'b1;
        n = 0;
        while (if_c.init_busy && n < 7) tick();
        chk("mid_sweep_cnt", n, 7);
        chk("mid_sweep_busy_c", if_c.init_busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        while (if_c.init_busy && n < 100) begin
            chk("resweep_valid_c", if_c.rd_valid, 0);
            tick();
        end
        chk("resweep_len_c", n, 16);
        while (if_a.init_busy && n < 1000) tick();
        chk("resweep_len_a", n, 256);

        // sweep wiped previously written words
        rd_check("resweep_a5", 8'hA5, 36'h0, 1'b0);
        rd_check("resweep_10", 8'h10, 36'h0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rx_dpram_ctl.md
Name: rx_dpram_ctl

Overview:
Parametrised single-clock simple dual-port receive buffer RAM: one write port, one read port, generalised in data width and depth. Adds a post-reset memory-clear sweep, an optional output register stage, write-first collision bypass, a read-valid strobe and optional per-word parity. Sits between the receive MAC datapath (writer) and the host-side DMA/AHB reader.

Parameters:
DWIDTH, 36, data word width in bits (1..72).
AWIDTH, 12, address width; depth = 2**AWIDTH words.
OUT_REG, 1, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
INIT_CLEAR, 1, 1 = zero every word after reset; 0 = no sweep, RUN immediately.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset_n  input  1  synchronous reset, active-low.
wr_en_n  input  1  write enable, active-low.
wr_addr  input  AWIDTH  write address.
wr_data  input  DWIDTH  write data.
par_inject  input  1  invert stored parity on this write (parity feature only).
rd_en  input  1  read request, active-high.
rd_addr  input  AWIDTH  read address.
rd_data  output  DWIDTH  read data.
rd_valid  output  1  one-cycle strobe, rd_data valid.
parity_err  output  1  parity mismatch on the word presented with rd_valid.
init_busy  output  1  high while clear sweep runs; user accesses ignored.

Behaviour:
- Clocking: one clock (clk). Reset: synchronous, active-low (reset_n), sampled on rising clk.
- During reset: rd_data=0, rd_valid=0, parity_err=0, pipeline flushed, init_cnt=0; init_busy=1 if INIT_CLEAR=1, else 0. Memory contents not reset directly.
- States: INIT, RUN. Reset release -> INIT if INIT_CLEAR=1, else RUN.
- INIT: each cycle writes all-zero word (parity bit 0) to mem[init_cnt], init_cnt++. After the write to address 2**AWIDTH-1 -> RUN; init_busy low from the next cycle. Sweep = 2**AWIDTH cycles. wr_en_n and rd_en ignored; rd_valid stays 0.
- RUN write: wr_en_n=0 at edge -> mem[wr_addr]=wr_data.
- RUN read: rd_en=1 at edge k -> rd_data=mem[rd_addr], rd_valid=1 in cycle after edge k+OUT_REG (latency 1+OUT_REG). Back-to-back reads every cycle: full throughput, in order.
- rd_valid is a pulse per accepted read; rd_data holds last read value while rd_valid=0.
- Collision (write and read same address, same edge): write-first, read returns the new wr_data. Different addresses: independent.
- Address wrap: none; depth is exactly 2**AWIDTH, all addresses legal.
- Reset mid-sweep or mid-read: in-flight reads dropped (no rd_valid), sweep restarts from address 0.
- OUT_REG=1: second stage delays rd_data, rd_valid and parity_err together; no stage can be stalled.

Optional Feature:
RX_DPRAM_PARITY_EN
- Defined: storage DWIDTH+1 bits; stored bit = even parity of wr_data XOR par_inject. On read, recomputed parity vs stored bit; mismatch drives parity_err=1 aligned with rd_valid (same pipeline delay); else 0. Collision bypass carries the bypassed parity bit (including injection).
- Not defined: storage DWIDTH bits, no parity logic; parity_err tied 0, par_inject ignored.

Test Plan:
- Reset, INIT_CLEAR=1, AWIDTH=4: init_busy high 16 cycles after reset_n rises, then low; read every address -> 0, rd_valid each cycle.
- OUT_REG=0: write 36'h9_ABCD_1234 to 0x0A5, rd_en at 0x0A5 next cycle -> rd_data=36'h9_ABCD_1234, rd_valid one cycle after rd_en; repeat OUT_REG=1 -> two cycles.
- Collision: same edge write 36'h1_2345_6789 to 0x010 and read 0x010 (old value 0) -> rd_data=36'h1_2345_6789.
- Write during INIT (wr_en_n=0, addr 3, data 36'hF_FFFF_FFFF) and rd_en during INIT -> no rd_valid; after sweep addr 3 reads 0.
- Reset asserted mid-sweep at init_cnt=7 and with reads in flight -> no rd_valid, sweep restarts at 0, full 2**AWIDTH cycles.
- RX_DPRAM_PARITY_EN: write 36'h0_0000_0001 with par_inject=1 to 0x020, read -> parity_err=1 with rd_valid; rewrite with par_inject=0, read -> parity_err=0.
